control_pipe: RTL and testbench

Control-signal pipeline for the 5-stage RISC-V core: it captures the decoded control word produced in Decode and carries it through the Execute, Memory and Writeback registers. It resolves the branch/jump redirect (PCSrcE) in Execute from the registered control and the ALU flags. It also keeps a retired-instruction counter for bring-up and performance checks. It sits directly downstream of the decode controller and upstream of the hazard unit, the ALU/memory muxes and the register-file write port.

---
 rtl/control_pipe.sv | 193 +++++++++++++++++++
 tb/tb_control_pipe.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/control_pipe.sv
// control_pipe: carries the decoded control word from Decode through the
// Execute, Memory and Writeback registers. It resolves the branch/jump
// redirect (PCSrcE) in Execute and counts retired instructions.
// Optional feature macro: CTRL_PIPE_FULL_BRANCH_EN
//   defined   -> all six RISC-V branch conditions are decoded from funct3
//   undefined -> beq only (taken = ZeroE); Funct3D, LtE and LtuE are unused
module control_pipe (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        FlushE,
    input  logic        ValidD,
    input  logic        RegWriteD,
    input  logic        MemWriteD,
    input  logic        JumpD,
    input  logic        BranchD,
    input  logic        ALUSrcD,
    input  logic [1:0]  ResultSrcD,
    input  logic [2:0]  ALUControlD,
    input  logic [2:0]  Funct3D,
    input  logic        ZeroE,
    input  logic        LtE,
    input  logic        LtuE,
    output logic        RegWriteE,
    output logic        MemWriteE,
    output logic        JumpE,
    output logic        BranchE,
    output logic        ALUSrcE,
    output logic [1:0]  ResultSrcE,
    output logic [2:0]  ALUControlE,
    output logic        PCSrcE,
    output logic        RegWriteM,
    output logic        MemWriteM,
    output logic [1:0]  ResultSrcM,
    output logic        RegWriteW,
    output logic [1:0]  ResultSrcW,
    output logic [31:0] RetireCount
);

    // Decode -> Execute bank
    logic        valid_e_q, valid_e_d;
    logic        reg_write_e_q, reg_write_e_d;
    logic        mem_write_e_q, mem_write_e_d;
    logic        jump_e_q, jump_e_d;
    logic        branch_e_q, branch_e_d;
    logic        alu_src_e_q, alu_src_e_d;
    logic [1:0]  result_src_e_q, result_src_e_d;
    logic [2:0]  alu_control_e_q, alu_control_e_d;
`ifdef CTRL_PIPE_FULL_BRANCH_EN
    logic [2:0]  funct3_e_q, funct3_e_d;
`endif

    // Execute -> Memory bank
    logic        valid_m_q;
    logic        reg_write_m_q;
    logic        mem_write_m_q;
    logic [1:0]  result_src_m_q;

    // Memory -> Writeback bank
    logic        valid_w_q;
    logic        reg_write_w_q;
    logic [1:0]  result_src_w_q;

    logic [31:0] retire_cnt_q, retire_cnt_d;
    logic        taken_s;

    // Next D->E contents: a flush overrides Decode and loads an all-zero bubble
    always_comb begin
        valid_e_d       = 1'b0;
        reg_write_e_d   = 1'b0;
        mem_write_e_d   = 1'b0;
        jump_e_d        = 1'b0;
        branch_e_d      = 1'b0;
        alu_src_e_d     = 1'b0;
        result_src_e_d  = 2'b00;
        alu_control_e_d = 3'b000;
`ifdef CTRL_PIPE_FULL_BRANCH_EN
        funct3_e_d      = 3'b000;
`endif
        if (FlushE) begin
            valid_e_d = 1'b0;
        end else begin
            valid_e_d       = ValidD;
            reg_write_e_d   = RegWriteD;
            mem_write_e_d   = MemWriteD;
            jump_e_d        = JumpD;
            branch_e_d      = BranchD;
            alu_src_e_d     = ALUSrcD;
            result_src_e_d  = ResultSrcD;
            alu_control_e_d = ALUControlD;
`ifdef CTRL_PIPE_FULL_BRANCH_EN
            funct3_e_d      = Funct3D;
`endif
        end
    end

    // Retire counter advances once per valid instruction leaving Writeback, wrapping at 2^32
    always_comb begin
        retire_cnt_d = retire_cnt_q;
        if (valid_w_q) begin
            retire_cnt_d = retire_cnt_q + 32'd1;
        end else begin
            retire_cnt_d = retire_cnt_q;
        end
    end

    // All pipeline banks and the counter; no stall path, every bank advances each edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_e_q       <= 1'b0;
            reg_write_e_q   <= 1'b0;
            mem_write_e_q   <= 1'b0;
            jump_e_q        <= 1'b0;
            branch_e_q      <= 1'b0;
            alu_src_e_q     <= 1'b0;
            result_src_e_q  <= 2'b00;
            alu_control_e_q <= 3'b000;
`ifdef CTRL_PIPE_FULL_BRANCH_EN
            funct3_e_q      <= 3'b000;
`endif
            valid_m_q       <= 1'b0;
            reg_write_m_q   <= 1'b0;
            mem_write_m_q   <= 1'b0;
            result_src_m_q  <= 2'b00;
            valid_w_q       <= 1'b0;
            reg_write_w_q   <= 1'b0;
            result_src_w_q  <= 2'b00;
            retire_cnt_q    <= 32'd0;
        end else begin
            valid_e_q       <= valid_e_d;
            reg_write_e_q   <= reg_write_e_d;
            mem_write_e_q   <= mem_write_e_d;
            jump_e_q        <= jump_e_d;
            branch_e_q      <= branch_e_d;
            alu_src_e_q     <= alu_src_e_d;
            result_src_e_q  <= result_src_e_d;
            alu_control_e_q <= alu_control_e_d;
`ifdef CTRL_PIPE_FULL_BRANCH_EN
            funct3_e_q      <= funct3_e_d;
`endif
            valid_m_q       <= valid_e_q;
            reg_write_m_q   <= reg_write_e_q;
            mem_write_m_q   <= mem_write_e_q;
            result_src_m_q  <= result_src_e_q;
            valid_w_q       <= valid_m_q;
            reg_write_w_q   <= reg_write_m_q;
            result_src_w_q  <= result_src_m_q;
            retire_cnt_q    <= retire_cnt_d;
        end
    end

`ifdef CTRL_PIPE_FULL_BRANCH_EN
    // Branch condition decoded from the registered funct3 and the live ALU flags
    always_comb begin
        taken_s = 1'b0;
        case (funct3_e_q)
            3'b000:  taken_s = ZeroE;
            3'b001:  taken_s = ~ZeroE;
            3'b100:  taken_s = LtE;
            3'b101:  taken_s = ~LtE;
            3'b110:  taken_s = LtuE;
            3'b111:  taken_s = ~LtuE;
            default: taken_s = 1'b0;
        endcase
    end
`else
    // beq-only core: equality flag alone decides the branch
    always_comb begin
        taken_s = ZeroE;
    end

    // funct3 and ordering flags have no consumer in the beq-only build
    logic unused_s;
    assign unused_s = ^{Funct3D, LtE, LtuE};
`endif

    // Redirect is combinational so it lands in the same cycle as the ALU flags
    assign PCSrcE      = jump_e_q | (branch_e_q & taken_s);

    assign RegWriteE   = reg_write_e_q;
    assign MemWriteE   = mem_write_e_q;
    assign JumpE       = jump_e_q;
    assign BranchE     = branch_e_q;
    assign ALUSrcE     = alu_src_e_q;
    assign ResultSrcE  = result_src_e_q;
    assign ALUControlE = alu_control_e_q;
    assign RegWriteM   = reg_write_m_q;
    assign MemWriteM   = mem_write_m_q;
    assign ResultSrcM  = result_src_m_q;
    assign RegWriteW   = reg_write_w_q;
    assign ResultSrcW  = result_src_w_q;
    assign RetireCount = retire_cnt_q;

endmodule

// File: tb/tb_control_pipe.sv
// Directed bench for control_pipe with a Writeback scoreboard.
// Each driven Decode slot pushes its expected Writeback image; the image is
// popped and compared once it reaches W. Retire count is modelled alongside.
module tb_control_pipe;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        FlushE, ValidD, RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD;
    logic [1:0]  ResultSrcD;
    logic [2:0]  ALUControlD, Funct3D;
    logic        ZeroE, LtE, LtuE;
    logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
    logic [1:0]  ResultSrcE;
    logic [2:0]  ALUControlE;
    logic        PCSrcE, RegWriteM, MemWriteM;
    logic [1:0]  ResultSrcM;
    logic        RegWriteW;
    logic [1:0]  ResultSrcW;
    logic [31:0] RetireCount;

    typedef struct packed {
        logic       v;
        logic       rw;
        logic [1:0] rs;
    } ent_t;

    ent_t sb_q[$];
    int   checks  = 0;
    int   errors  = 0;
    int   exp_cnt = 0;

    control_pipe dut (
        .clk(clk), .reset_n(reset_n), .FlushE(FlushE), .ValidD(ValidD),
        .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .JumpD(JumpD),
        .BranchD(BranchD), .ALUSrcD(ALUSrcD), .ResultSrcD(ResultSrcD),
        .ALUControlD(ALUControlD), .Funct3D(Funct3D), .ZeroE(ZeroE),
        .LtE(LtE), .LtuE(LtuE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
        .JumpE(JumpE), .BranchE(BranchE), .ALUSrcE(ALUSrcE),
        .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE), .PCSrcE(PCSrcE),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RetireCount(RetireCount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return {14'd0, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE,
                ALUControlE, PCSrcE, RegWriteM, MemWriteM, ResultSrcM, RegWriteW,
                ResultSrcW};
    endfunction

    // Scoreboard restart: pipeline holds two bubbles ahead of the next slot
    task automatic sb_reset();
        ent_t b;
        b = '0;
        sb_q.delete();
        sb_q.push_back(b);
        sb_q.push_back(b);
        exp_cnt = 0;
    endtask

    // Assert reset now (between edges), check immediate clear, hold, release
    task automatic do_reset(input int cycles);
        reset_n = 1'b0;
        #1;
        chk("rst_outs_async", all_outs(), 32'd0);
        chk("rst_count_async", RetireCount, 32'd0);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            chk("rst_outs_hold", all_outs(), 32'd0);
            chk("rst_count_hold", RetireCount, 32'd0);
        end
        reset_n = 1'b1;
        sb_reset();
    endtask

    // Drive one Decode slot, advance one edge, compare the slot now in W
    task automatic drive(input logic v, input logic rw, input logic mw,
                         input logic j, input logic b, input logic [1:0] rs,
                         input logic [2:0] f3, input logic fl);
        ent_t e;
        ent_t w;
        ValidD = v; RegWriteD = rw; MemWriteD = mw; JumpD = j; BranchD = b;
        ALUSrcD = 1'b0; ResultSrcD = rs; ALUControlD = 3'b010; Funct3D = f3;
        FlushE = fl;
        if (fl) begin
            e = '0;
        end else begin
            e.v = v; e.rw = rw; e.rs = rs;
        end
        sb_q.push_back(e);
        @(posedge clk); #1;
        w = sb_q.pop_front();
        chk("w_regwrite", {31'd0, RegWriteW}, {31'd0, w.rw});
        chk("w_resultsrc", {30'd0, ResultSrcW}, {30'd0, w.rs});
        chk("retire_count", RetireCount, exp_cnt);
        if (w.v) exp_cnt++;
    endtask

    task automatic bubble();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 1'b0);
    endtask

    initial begin
        // Reset with every D input high
        FlushE = 1'b0; ValidD = 1'b1; RegWriteD = 1'b1; MemWriteD = 1'b1;
        JumpD = 1'b1; BranchD = 1'b1; ALUSrcD = 1'b1; ResultSrcD = 2'b11;
        ALUControlD = 3'b111; Funct3D = 3'b111; ZeroE = 1'b1; LtE = 1'b1; LtuE = 1'b1;
        do_reset(3);
        ZeroE = 1'b0; LtE = 1'b0; LtuE = 1'b0;

        // First instruction after release
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 3'b000, 1'b0);
        chk("rel_regwrite_e", {31'd0, RegWriteE}, 32'd1);
        chk("rel_resultsrc_e", {30'd0, ResultSrcE}, 32'd1);
        bubble();
        bubble();
        chk("rel_resultsrc_w", {30'd0, ResultSrcW}, 32'd1);
        bubble();
        chk("rel_retire_1", RetireCount, 32'd1);

        // Flush beats ValidD
        ZeroE = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 3'b000, 1'b1);
        chk("flush_memwrite_e", {31'd0, MemWriteE}, 32'd0);
        chk("flush_jump_e", {31'd0, JumpE}, 32'd0);
        chk("flush_pcsrc", {31'd0, PCSrcE}, 32'd0);
        ZeroE = 1'b0; #1;
        chk("flush_pcsrc_tog", {31'd0, PCSrcE}, 32'd0);
        bubble();
        chk("flush_memwrite_m", {31'd0, MemWriteM}, 32'd0);
        bubble();
        bubble();
        bubble();
        chk("flush_retire", RetireCount, 32'd1);

        // beq and jump
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 3'b000, 1'b0);
        ZeroE = 1'b1; #1;
        chk("beq_taken", {31'd0, PCSrcE}, 32'd1);
        ZeroE = 1'b0; #1;
        chk("beq_not_taken", {31'd0, PCSrcE}, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 3'b000, 1'b0);
        chk("jump_z0", {31'd0, PCSrcE}, 32'd1);
        ZeroE = 1'b1; LtE = 1'b1; #1;
        chk("jump_z1", {31'd0, PCSrcE}, 32'd1);
        ZeroE = 1'b0; LtE = 1'b0;

        // bne: taken only when full branch decode is built in
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 3'b001, 1'b0);
        #1;
`ifdef CTRL_PIPE_FULL_BRANCH_EN
        chk("bne_z0", {31'd0, PCSrcE}, 32'd1);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 3'b101, 1'b0);
        LtE = 1'b1; #1;
        chk("bge_lt1", {31'd0, PCSrcE}, 32'd0);
        LtE = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 3'b110, 1'b0);
        LtuE = 1'b1; #1;
        chk("bltu_ltu1", {31'd0, PCSrcE}, 32'd1);
        LtuE = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 3'b010, 1'b0);
        ZeroE = 1'b1; LtE = 1'b1; LtuE = 1'b1; #1;
        chk("f3_010", {31'd0, PCSrcE}, 32'd0);
        ZeroE = 1'b0; LtE = 1'b0; LtuE = 1'b0;
`else
        chk("bne_beq_only", {31'd0, PCSrcE}, 32'd0);
        LtE = 1'b1; LtuE = 1'b1; #1;
        chk("bne_flags_ignored", {31'd0, PCSrcE}, 32'd0);
        LtE = 1'b0; LtuE = 1'b0;
`endif

        // Streaming from a clean count
        #2;
        do_reset(1);
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'(i % 4), 3'b000, 1'b0);
        end
        bubble();
        bubble();
        bubble();
        chk("stream_10", RetireCount, 32'd10);
        bubble();
        bubble();
        chk("stream_hold_10", RetireCount, 32'd10);

        // Reset while three instructions are in flight
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 3'b000, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 3'b000, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b11, 3'b000, 1'b0);
        chk("mid_pre_jump_e", {31'd0, JumpE}, 32'd1);
        #2;
        do_reset(2);
        ValidD = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bubble();
        end
        chk("mid_no_count", RetireCount, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
